// File: rtl/mux_seq_pkg.sv
// Shared defaults, widths and FSM states
// for the sequenced mux controller.
package mux_seq_pkg;

  localparam int N_SEL_DEF  = 6;
  localparam int DEPTH_DEF  = 16;
  localparam int N_MODE_DEF = 4;

  localparam int SEL_W_DEF  = $clog2(N_SEL_DEF);
  localparam int IDX_W_DEF  = $clog2(DEPTH_DEF);
  localparam int MODE_W_DEF = $clog2(N_MODE_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_seq_table.sv
// Per-mode select table and sequence length,
// with write validation and sticky error.
module mux_seq_table
  import mux_seq_pkg::*;
#(
  parameter int N_SEL  = N_SEL_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int N_MODE = N_MODE_DEF
) (
  input  logic                      SYS_CLK,
  input  logic                      SYS_RST,
  input  logic                      cfg_we_i,
  input  logic [$clog2(N_MODE)-1:0] cfg_mode_i,
  input  logic [$clog2(DEPTH)-1:0]  cfg_addr_i,
  input  logic [$clog2(N_SEL)-1:0]  cfg_data_i,
  input  logic                      cfg_len_we_i,
  input  logic [$clog2(DEPTH):0]    cfg_len_i,
  input  logic [$clog2(N_MODE)-1:0] rd_mode_i,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx_i,
  output logic [$clog2(N_SEL)-1:0]  rd_sel_o,
  output logic [$clog2(DEPTH):0]    rd_len_o,
  output logic                      cfg_err_o
);

  localparam int SEL_W = $clog2(N_SEL);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic [SEL_W-1:0] tbl_q [N_MODE][DEPTH];
  logic [LEN_W-1:0] len_q [N_MODE];
  logic             err_q;

  logic [31:0] mode_x;
  logic [31:0] data_x;
  logic [31:0] len_x;
  logic        mode_ok;
  logic        data_ok;
  logic        len_ok;
  logic        tbl_wr;
  logic        len_wr;
  logic        bad_wr;

  // Validate incoming writes against table geometry
  always_comb begin
    mode_x  = 32'(cfg_mode_i);
    data_x  = 32'(cfg_data_i);
    len_x   = 32'(cfg_len_i);
    mode_ok = mode_x < 32'(N_MODE);
    data_ok = data_x < 32'(N_SEL);
    len_ok  = (len_x != 32'd0) &&
              (len_x <= 32'(DEPTH));
    tbl_wr  = cfg_we_i && mode_ok && data_ok;
    len_wr  = cfg_len_we_i && mode_ok && len_ok;
    bad_wr  = (cfg_we_i && !tbl_wr) ||
              (cfg_len_we_i && !len_wr);
  end

  // Storage: identity-ish default on reset, validated writes after
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      for (int m = 0; m < N_MODE; m++) begin
        for (int k = 0; k < DEPTH; k++) begin
          tbl_q[m][k] <= SEL_W'(k % N_SEL);
        end
        len_q[m] <= LEN_W'(N_SEL);
      end
      err_q <= 1'b0;
    end else begin
      if (tbl_wr) begin
        tbl_q[cfg_mode_i][cfg_addr_i] <= cfg_data_i;
      end
      if (len_wr) begin
        len_q[cfg_mode_i] <= cfg_len_i;
      end
      if (bad_wr) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rd_sel_o  = tbl_q[rd_mode_i][rd_idx_i];
  assign rd_len_o  = len_q[rd_mode_i];
  assign cfg_err_o = err_q;

endmodule

// File: rtl/mux_seq_ctrl.sv
// Mode FSM and step index driving a mux select
// from a per-mode programmable sequence.
module mux_seq_ctrl
  import mux_seq_pkg::*;
#(
  parameter int N_SEL  = N_SEL_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int N_MODE = N_MODE_DEF
) (
  input  logic                      SYS_CLK,
  input  logic                      SYS_RST,
  input  logic [N_MODE-1:0]         mode_i,
  input  logic                      ctrl_update_i,
  input  logic                      ctrl_reset_i,
  input  logic                      cfg_we_i,
  input  logic [$clog2(N_MODE)-1:0] cfg_mode_i,
  input  logic [$clog2(DEPTH)-1:0]  cfg_addr_i,
  input  logic [$clog2(N_SEL)-1:0]  cfg_data_i,
  input  logic                      cfg_len_we_i,
  input  logic [$clog2(DEPTH):0]    cfg_len_i,
  output logic [$clog2(N_SEL)-1:0]  ctrl_mux_o,
  output logic [$clog2(DEPTH)-1:0]  ctrl_idx_o,
  output logic                      wrap_o,
  output logic                      mode_err_o,
  output logic                      cfg_err_o
);

  localparam int SEL_W  = $clog2(N_SEL);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MODE_W = $clog2(N_MODE);

  state_t            state_q;
  state_t            state_d;
  logic [MODE_W-1:0] act_q;
  logic [MODE_W-1:0] act_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              wrap_q;
  logic              wrap_d;
  logic              zero;
  logic              multi;
  logic              run_q;
  logic              chg;
  logic              at_end;
  logic [SEL_W-1:0]  rd_sel;
  logic [IDX_W:0]    rd_len;

  mux_seq_table #(
    .N_SEL  (N_SEL),
    .DEPTH  (DEPTH),
    .N_MODE (N_MODE)
  ) u_table (
    .SYS_CLK      (SYS_CLK),
    .SYS_RST      (SYS_RST),
    .cfg_we_i     (cfg_we_i),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_len_we_i (cfg_len_we_i),
    .cfg_len_i    (cfg_len_i),
    .rd_mode_i    (act_q),
    .rd_idx_i     (idx_q),
    .rd_sel_o     (rd_sel),
    .rd_len_o     (rd_len),
    .cfg_err_o    (cfg_err_o)
  );

  // Next state, active mode, index and wrap pulse
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    zero    = ~|mode_i;
    multi   = |(mode_i & (mode_i - 1'b1));
    run_q   = (state_q == S_RUN);
    at_end  = ((IDX_W+1)'(idx_q) + 1'b1) >= rd_len;

    unique case (1'b1)
      zero:    state_d = S_IDLE;
      multi:   state_d = S_ERR;
      default: state_d = S_RUN;
    endcase

    for (int i = N_MODE - 1; i >= 0; i--) begin
      if (mode_i[i]) begin
        act_d = MODE_W'(i);
      end
    end

    // Entering RUN, or switching mode while in RUN, restarts the sequence
    chg = (state_d == S_RUN) &&
          (!run_q || (act_d != act_q));

    if (ctrl_reset_i) begin
      idx_d = '0;
    end else if (chg) begin
      idx_d = '0;
    end else if (ctrl_update_i && run_q) begin
      if (at_end) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State, mode and index registers
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q <= S_IDLE;
      act_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ctrl_mux_o = (state_q == S_RUN) ? rd_sel : '0;
  assign ctrl_idx_o = idx_q;
  assign wrap_o     = wrap_q;
  assign mode_err_o = (state_q == S_ERR);

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Directed bench for mux_seq_ctrl with
// hand-computed expected values.
module tb_mux_seq_ctrl;
  import mux_seq_pkg::*;

  logic                  SYS_CLK;
  logic                  SYS_RST;
  logic [N_MODE_DEF-1:0] mode_i;
  logic                  ctrl_update_i;
  logic                  ctrl_reset_i;
  logic                  cfg_we_i;
  logic [MODE_W_DEF-1:0] cfg_mode_i;
  logic [IDX_W_DEF-1:0]  cfg_addr_i;
  logic [SEL_W_DEF-1:0]  cfg_data_i;
  logic                  cfg_len_we_i;
  logic [IDX_W_DEF:0]    cfg_len_i;
  logic [SEL_W_DEF-1:0]  ctrl_mux_o;
  logic [IDX_W_DEF-1:0]  ctrl_idx_o;
  logic                  wrap_o;
  logic                  mode_err_o;
  logic                  cfg_err_o;

  int n_vec;
  int n_err;

  mux_seq_ctrl dut (
    .SYS_CLK       (SYS_CLK),
    .SYS_RST       (SYS_RST),
    .mode_i        (mode_i),
    .ctrl_update_i (ctrl_update_i),
    .ctrl_reset_i  (ctrl_reset_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_mode_i    (cfg_mode_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_data_i    (cfg_data_i),
    .cfg_len_we_i  (cfg_len_we_i),
    .cfg_len_i     (cfg_len_i),
    .ctrl_mux_o    (ctrl_mux_o),
    .ctrl_idx_o    (ctrl_idx_o),
    .wrap_o        (wrap_o),
    .mode_err_o    (mode_err_o),
    .cfg_err_o     (cfg_err_o)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic upd(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_update_i = 1'b1;
      tick();
    end
    ctrl_update_i = 1'b0;
  endtask

  task automatic test_reset();
    SYS_RST = 1'b1;
    mode_i = 4'b0001;
    ctrl_update_i = 1'b1;
    tick();
    tick();
    ctrl_update_i = 1'b0;
    n_vec++;
    if (ctrl_mux_o !== 3'd0 || ctrl_idx_o !== 4'd0 ||
        wrap_o !== 1'b0 || mode_err_o !== 1'b0 ||
        cfg_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset mux=%0d idx=%0d wrap=%b merr=%b cerr=%b want all 0",
               ctrl_mux_o, ctrl_idx_o, wrap_o, mode_err_o, cfg_err_o);
    end
    SYS_RST = 1'b0;
  endtask

  task automatic test_basic();
    int exp_mux [7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_wr [7]  = '{0, 0, 0, 0, 0, 1, 0};
    mode_i = 4'b0001;
    tick();
    n_vec++;
    if (ctrl_mux_o !== 3'd0 || ctrl_idx_o !== 4'd0) begin
      n_err++;
      $display("FAIL basic_start mux=%0d idx=%0d want 0 0",
               ctrl_mux_o, ctrl_idx_o);
    end
    for (int i = 0; i < 7; i++) begin
      upd(1);
      n_vec++;
      if (ctrl_mux_o !== 3'(exp_mux[i]) ||
          wrap_o !== 1'(exp_wr[i])) begin
        n_err++;
        $display("FAIL basic_step%0d mux=%0d wrap=%b want %0d %0d",
                 i, ctrl_mux_o, wrap_o, exp_mux[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_cfg_seq();
    int dat [3]     = '{0, 3, 4};
    int exp_mux [4] = '{3, 4, 0, 3};
    int exp_wr [4]  = '{0, 0, 1, 0};
    cfg_len_we_i = 1'b1;
    cfg_mode_i = 2'd1;
    cfg_len_i = 5'd3;
    tick();
    cfg_len_we_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_we_i = 1'b1;
      cfg_addr_i = 4'(i);
      cfg_data_i = 3'(dat[i]);
      tick();
    end
    cfg_we_i = 1'b0;
    n_vec++;
    if (cfg_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_valid cerr=%b want 0", cfg_err_o);
    end
    mode_i = 4'b0010;
    tick();
    n_vec++;
    if (ctrl_mux_o !== 3'd0 || ctrl_idx_o !== 4'd0) begin
      n_err++;
      $display("FAIL cfg_start mux=%0d idx=%0d want 0 0",
               ctrl_mux_o, ctrl_idx_o);
    end
    for (int i = 0; i < 4; i++) begin
      upd(1);
      n_vec++;
      if (ctrl_mux_o !== 3'(exp_mux[i]) ||
          wrap_o !== 1'(exp_wr[i])) begin
        n_err++;
        $display("FAIL cfg_step%0d mux=%0d wrap=%b want %0d %0d",
                 i, ctrl_mux_o, wrap_o, exp_mux[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_mode_change();
    mode_i = 4'b0001;
    tick();
    upd(2);
    n_vec++;
    if (ctrl_idx_o !== 4'd2 || ctrl_mux_o !== 3'd2) begin
      n_err++;
      $display("FAIL mchg_pre idx=%0d mux=%0d want 2 2",
               ctrl_idx_o, ctrl_mux_o);
    end
    mode_i = 4'b0100;
    upd(1);
    n_vec++;
    if (ctrl_idx_o !== 4'd0 || wrap_o !== 1'b0) begin
      n_err++;
      $display("FAIL mchg idx=%0d wrap=%b want 0 0",
               ctrl_idx_o, wrap_o);
    end
    upd(1);
    n_vec++;
    if (ctrl_idx_o !== 4'd1 || ctrl_mux_o !== 3'd1) begin
      n_err++;
      $display("FAIL mchg_post idx=%0d mux=%0d want 1 1",
               ctrl_idx_o, ctrl_mux_o);
    end
  endtask

  task automatic test_ctrl_reset();
    upd(3);
    n_vec++;
    if (ctrl_idx_o !== 4'd4 || ctrl_mux_o !== 3'd4) begin
      n_err++;
      $display("FAIL creset_pre idx=%0d mux=%0d want 4 4",
               ctrl_idx_o, ctrl_mux_o);
    end
    ctrl_reset_i = 1'b1;
    upd(1);
    ctrl_reset_i = 1'b0;
    n_vec++;
    if (ctrl_idx_o !== 4'd0 || wrap_o !== 1'b0 ||
        ctrl_mux_o !== 3'd0) begin
      n_err++;
      $display("FAIL creset idx=%0d wrap=%b mux=%0d want 0 0 0",
               ctrl_idx_o, wrap_o, ctrl_mux_o);
    end
  endtask

  task automatic test_mode_err();
    upd(2);
    mode_i = 4'b0011;
    tick();
    n_vec++;
    if (mode_err_o !== 1'b1 || ctrl_mux_o !== 3'd0 ||
        ctrl_idx_o !== 4'd2) begin
      n_err++;
      $display("FAIL merr merr=%b mux=%0d idx=%0d want 1 0 2",
               mode_err_o, ctrl_mux_o, ctrl_idx_o);
    end
    for (int i = 0; i < 2; i++) begin
      upd(1);
      n_vec++;
      if (ctrl_idx_o !== 4'd2 || ctrl_mux_o !== 3'd0 ||
          wrap_o !== 1'b0) begin
        n_err++;
        $display("FAIL merr_frz%0d idx=%0d mux=%0d wrap=%b want 2 0 0",
                 i, ctrl_idx_o, ctrl_mux_o, wrap_o);
      end
    end
    mode_i = 4'b0000;
    upd(1);
    n_vec++;
    if (mode_err_o !== 1'b0 || ctrl_mux_o !== 3'd0 ||
        ctrl_idx_o !== 4'd2) begin
      n_err++;
      $display("FAIL idle merr=%b mux=%0d idx=%0d want 0 0 2",
               mode_err_o, ctrl_mux_o, ctrl_idx_o);
    end
  endtask

  task automatic test_cfg_err();
    mode_i = 4'b0100;
    tick();
    cfg_we_i = 1'b1;
    cfg_mode_i = 2'd2;
    cfg_addr_i = 4'd1;
    cfg_data_i = 3'd6;
    tick();
    cfg_we_i = 1'b0;
    n_vec++;
    if (cfg_err_o !== 1'b1) begin
      n_err++;
      $display("FAIL cerr_data cerr=%b want 1", cfg_err_o);
    end
    upd(1);
    n_vec++;
    if (ctrl_idx_o !== 4'd1 || ctrl_mux_o !== 3'd1) begin
      n_err++;
      $display("FAIL cerr_discard idx=%0d mux=%0d want 1 1",
               ctrl_idx_o, ctrl_mux_o);
    end
    cfg_len_we_i = 1'b1;
    cfg_len_i = 5'd0;
    tick();
    cfg_len_we_i = 1'b0;
    upd(1);
    n_vec++;
    if (ctrl_idx_o !== 4'd2 || wrap_o !== 1'b0) begin
      n_err++;
      $display("FAIL cerr_len idx=%0d wrap=%b want 2 0",
               ctrl_idx_o, wrap_o);
    end
    tick();
    tick();
    n_vec++;
    if (cfg_err_o !== 1'b1) begin
      n_err++;
      $display("FAIL cerr_sticky cerr=%b want 1", cfg_err_o);
    end
    SYS_RST = 1'b1;
    tick();
    SYS_RST = 1'b0;
    n_vec++;
    if (cfg_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL cerr_clr cerr=%b want 0", cfg_err_o);
    end
  endtask

  task automatic test_shrink();
    mode_i = 4'b0001;
    tick();
    upd(3);
    cfg_len_we_i = 1'b1;
    cfg_len_i = 5'd2;
    cfg_we_i = 1'b1;
    cfg_mode_i = 2'd0;
    cfg_addr_i = 4'd0;
    cfg_data_i = 3'd5;
    upd(1);
    cfg_len_we_i = 1'b0;
    cfg_we_i = 1'b0;
    n_vec++;
    if (ctrl_idx_o !== 4'd4 || ctrl_mux_o !== 3'd4 ||
        cfg_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL both_wr idx=%0d mux=%0d cerr=%b want 4 4 0",
               ctrl_idx_o, ctrl_mux_o, cfg_err_o);
    end
    upd(1);
    n_vec++;
    if (ctrl_idx_o !== 4'd0 || wrap_o !== 1'b1 ||
        ctrl_mux_o !== 3'd5) begin
      n_err++;
      $display("FAIL shrink idx=%0d wrap=%b mux=%0d want 0 1 5",
               ctrl_idx_o, wrap_o, ctrl_mux_o);
    end
  endtask

  task automatic test_reset_mid();
    upd(1);
    n_vec++;
    if (ctrl_idx_o !== 4'd1 || ctrl_mux_o !== 3'd1) begin
      n_err++;
      $display("FAIL rmid_pre idx=%0d mux=%0d want 1 1",
               ctrl_idx_o, ctrl_mux_o);
    end
    SYS_RST = 1'b1;
    cfg_we_i = 1'b1;
    cfg_data_i = 3'd7;
    upd(1);
    SYS_RST = 1'b0;
    cfg_we_i = 1'b0;
    n_vec++;
    if (ctrl_idx_o !== 4'd0 || ctrl_mux_o !== 3'd0 ||
        wrap_o !== 1'b0 || cfg_err_o !== 1'b0 ||
        mode_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL rmid idx=%0d mux=%0d wrap=%b cerr=%b merr=%b want 0",
               ctrl_idx_o, ctrl_mux_o, wrap_o, cfg_err_o, mode_err_o);
    end
    tick();
    n_vec++;
    if (ctrl_mux_o !== 3'd0 || ctrl_idx_o !== 4'd0) begin
      n_err++;
      $display("FAIL rmid_tbl mux=%0d idx=%0d want 0 0",
               ctrl_mux_o, ctrl_idx_o);
    end
    upd(1);
    n_vec++;
    if (ctrl_mux_o !== 3'd1) begin
      n_err++;
      $display("FAIL rmid_run mux=%0d want 1", ctrl_mux_o);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    SYS_RST = 1'b1;
    mode_i = '0;
    ctrl_update_i = 1'b0;
    ctrl_reset_i = 1'b0;
    cfg_we_i = 1'b0;
    cfg_mode_i = '0;
    cfg_addr_i = '0;
    cfg_data_i = '0;
    cfg_len_we_i = 1'b0;
    cfg_len_i = '0;
    test_reset();
    test_basic();
    test_cfg_seq();
    test_mode_change();
    test_ctrl_reset();
    test_mode_err();
    test_cfg_err();
    test_shrink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
